// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle light FSM: grants WALK then
// flashing DON'T-WALK inside the red interval, with abort on early red drop and sticky fault.
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6,
    parameter int FLASH_HALF   = 1,
    parameter int CNT_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             r,
    input  logic             y,
    input  logic             g,
    input  logic             ped_button,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort,
    output logic             fault
);

    typedef enum logic [1:0] {
        DONT_WALK,
        WALK,
        FLASH,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FLASH = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(FLASH_HALF - 1);

    state_t           state_q;
    logic             sync1_q, sync2_q, sync3_q;
    logic             r_q;
    logic             walk_q, dont_walk_q, flash_q, req_pending_q, abort_q, fault_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;

    logic req_set, red_rise, onehot;

    assign req_set  = sync2_q & ~sync3_q;
    assign red_rise = r & ~r_q;
    // Odd number of lamps lit, excluding all three, is exactly one-hot for three bits.
    assign onehot   = (r ^ y ^ g) & ~(r & y & g);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= DONT_WALK;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            r_q           <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            flash_q       <= 1'b0;
            req_pending_q <= 1'b0;
            abort_q       <= 1'b0;
            fault_q       <= 1'b0;
            cnt_q         <= '0;
            half_q        <= '0;
        end else begin
            sync1_q <= ped_button;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            r_q     <= r;
            abort_q <= 1'b0;
            if (!onehot) begin
                state_q     <= FAULT;
                fault_q     <= 1'b1;
                walk_q      <= 1'b0;
                dont_walk_q <= 1'b1;
                flash_q     <= 1'b0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    DONT_WALK: begin
                        if (red_rise && (req_pending_q || req_set)) begin
                            state_q       <= WALK;
                            walk_q        <= 1'b1;
                            dont_walk_q   <= 1'b0;
                            req_pending_q <= 1'b0;
                            cnt_q         <= CNT_LOAD;
                        end else if (req_set) begin
                            req_pending_q <= 1'b1;
                        end
                    end
                    WALK: begin
                        if (!r) begin
                            state_q     <= DONT_WALK;
                            walk_q      <= 1'b0;
                            dont_walk_q <= 1'b1;
                            cnt_q       <= '0;
                            abort_q     <= 1'b1;
                        end else if (cnt_q == CNT_FLASH) begin
                            state_q     <= FLASH;
                            walk_q      <= 1'b0;
                            flash_q     <= 1'b1;
                            dont_walk_q <= 1'b1;
                            half_q      <= '0;
                            cnt_q       <= cnt_q - 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    FLASH: begin
                        // A request during clearance is kept for the next red interval.
                        if (req_set) begin
                            req_pending_q <= 1'b1;
                        end
                        if (!r) begin
                            state_q     <= DONT_WALK;
                            flash_q     <= 1'b0;
                            dont_walk_q <= 1'b1;
                            cnt_q       <= '0;
                            abort_q     <= 1'b1;
                        end else if (cnt_q == '0) begin
                            state_q     <= DONT_WALK;
                            flash_q     <= 1'b0;
                            dont_walk_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                            if (half_q == HALF_LAST) begin
                                dont_walk_q <= ~dont_walk_q;
                                half_q      <= '0;
                            end else begin
                                half_q <= half_q + 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                        state_q <= FAULT;
                    end
                    default: begin
                        state_q <= FAULT;
                    end
                endcase
            end
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign flash       = flash_q;
    assign countdown   = cnt_q;
    assign req_pending = req_pending_q;
    assign abort       = abort_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_ped_crossing_ctrl;

    logic       clock = 1'b0;
    logic       reset, r, y, g, ped_button;
    logic       walk, dont_walk, flash, req_pending, abort, fault;
    logic [4:0] countdown;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    ped_crossing_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .r          (r),
        .y          (y),
        .g          (g),
        .ped_button (ped_button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .flash      (flash),
        .countdown  (countdown),
        .req_pending(req_pending),
        .abort      (abort),
        .fault      (fault)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic goGreen();
        r = 1'b0; y = 1'b0; g = 1'b1;
        tick();
    endtask

    // Press during green, release, then raise red: returns just after the grant edge.
    task automatic pressAndGrant();
        ped_button = 1'b1;
        repeat (3) tick();
        ped_button = 1'b0;
        r = 1'b1; y = 1'b0; g = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; r = 1'b1; y = 1'b0; g = 1'b0; ped_button = 1'b0;
        tick();
        tick();
        testsRun++;
        if ({walk, dont_walk, flash, countdown, req_pending, abort, fault} !== 11'b0_1_0_00000_0_0_0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state got %b want %b",
                     {walk, dont_walk, flash, countdown, req_pending, abort, fault}, 11'b0_1_0_00000_0_0_0);
        end
        reset = 1'b0;
    endtask

    task automatic test_walk_flash();
        goGreen();
        tick();
        ped_button = 1'b1;
        tick();
        tick();
        testsRun++;
        if (req_pending !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL req_early got %b want 0", req_pending);
        end
        tick();
        testsRun++;
        if (req_pending !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL req_latency got %b want 1", req_pending);
        end
        ped_button = 1'b0; g = 1'b0; y = 1'b1;
        tick();
        y = 1'b0; r = 1'b1;
        tick();
        testsRun++;
        if (req_pending !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL req_clear_on_grant got %b want 0", req_pending);
        end
        for (int k = 0; k < 8; k++) begin
            testsRun++;
            if ({walk, dont_walk, flash, countdown} !== {1'b1, 1'b0, 1'b0, 5'(13 - k)}) begin
                testsFailed++;
                $display("[TB] FAIL walk_cycle%0d got %b want %b", k,
                         {walk, dont_walk, flash, countdown}, {1'b1, 1'b0, 1'b0, 5'(13 - k)});
            end
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            testsRun++;
            if ({walk, dont_walk, flash, countdown} !== {1'b0, (j % 2 == 0), 1'b1, 5'(5 - j)}) begin
                testsFailed++;
                $display("[TB] FAIL flash_cycle%0d got %b want %b", j,
                         {walk, dont_walk, flash, countdown}, {1'b0, (j % 2 == 0), 1'b1, 5'(5 - j)});
            end
            tick();
        end
        testsRun++;
        if ({walk, dont_walk, flash, countdown, abort} !== 9'b0_1_0_00000_0) begin
            testsFailed++;
            $display("[TB] FAIL after_crossing got %b want %b",
                     {walk, dont_walk, flash, countdown, abort}, 9'b0_1_0_00000_0);
        end
        goGreen();
    endtask

    task automatic test_no_press();
        r = 1'b1; g = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            testsRun++;
            if ({walk, countdown, req_pending} !== 7'b0) begin
                testsFailed++;
                $display("[TB] FAIL no_press_cycle%0d got %b want 0000000", i, {walk, countdown, req_pending});
            end
        end
        goGreen();
    endtask

    task automatic test_press_at_red_rise();
        ped_button = 1'b1;
        tick();
        tick();
        r = 1'b1; g = 1'b0;
        tick();
        ped_button = 1'b0;
        testsRun++;
        if ({walk, dont_walk, countdown, req_pending} !== {1'b1, 1'b0, 5'd13, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_grant got %b want %b",
                     {walk, dont_walk, countdown, req_pending}, {1'b1, 1'b0, 5'd13, 1'b0});
        end
        repeat (14) tick();
        testsRun++;
        if ({walk, dont_walk, flash, countdown} !== 8'b0_1_0_00000) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_end got %b want 01000000", {walk, dont_walk, flash, countdown});
        end
        goGreen();
    endtask

    task automatic test_press_walk_flash();
        pressAndGrant();
        tick();
        ped_button = 1'b1;
        repeat (3) tick();
        ped_button = 1'b0;
        repeat (3) tick();
        testsRun++;
        if ({req_pending, walk, countdown} !== {1'b0, 1'b1, 5'd6}) begin
            testsFailed++;
            $display("[TB] FAIL press_in_walk got %b want %b", {req_pending, walk, countdown}, {1'b0, 1'b1, 5'd6});
        end
        tick();
        ped_button = 1'b1;
        repeat (3) tick();
        ped_button = 1'b0;
        testsRun++;
        if ({req_pending, flash, countdown} !== {1'b1, 1'b1, 5'd2}) begin
            testsFailed++;
            $display("[TB] FAIL press_in_flash got %b want %b", {req_pending, flash, countdown}, {1'b1, 1'b1, 5'd2});
        end
        repeat (3) tick();
        testsRun++;
        if ({walk, dont_walk, flash, countdown, req_pending} !== 9'b0_1_0_00000_1) begin
            testsFailed++;
            $display("[TB] FAIL flash_req_held got %b want 010000001",
                     {walk, dont_walk, flash, countdown, req_pending});
        end
        goGreen();
        testsRun++;
        if ({walk, req_pending} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL wait_next_red got %b want 01", {walk, req_pending});
        end
        r = 1'b1; g = 1'b0;
        tick();
        testsRun++;
        if ({walk, countdown, req_pending} !== {1'b1, 5'd13, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL served_next_red got %b want %b", {walk, countdown, req_pending}, {1'b1, 5'd13, 1'b0});
        end
        repeat (14) tick();
        goGreen();
    endtask

    task automatic test_abort();
        pressAndGrant();
        repeat (3) tick();
        r = 1'b0; g = 1'b1;
        tick();
        testsRun++;
        if ({walk, dont_walk, flash, countdown, abort} !== 9'b0_1_0_00000_1) begin
            testsFailed++;
            $display("[TB] FAIL abort_edge got %b want 010000001", {walk, dont_walk, flash, countdown, abort});
        end
        tick();
        testsRun++;
        if ({walk, abort, fault} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL abort_one_cycle got %b want 000", {walk, abort, fault});
        end
    endtask

    task automatic test_fault();
        r = 1'b1;
        tick();
        testsRun++;
        if ({fault, dont_walk, walk} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL fault_set got %b want 110", {fault, dont_walk, walk});
        end
        r = 1'b0;
        tick();
        tick();
        testsRun++;
        if ({fault, dont_walk, walk} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL fault_sticky got %b want 110", {fault, dont_walk, walk});
        end
        pressAndGrant();
        testsRun++;
        if ({fault, walk, countdown} !== 7'b1_0_00000) begin
            testsFailed++;
            $display("[TB] FAIL fault_blocks_grant got %b want 1000000", {fault, walk, countdown});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if ({fault, dont_walk, walk, req_pending} !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL fault_reset got %b want 0100", {fault, dont_walk, walk, req_pending});
        end
        goGreen();
        pressAndGrant();
        tick();
        r = 1'b0; y = 1'b0; g = 1'b0;
        tick();
        testsRun++;
        if ({fault, abort, walk, dont_walk} !== 4'b1001) begin
            testsFailed++;
            $display("[TB] FAIL fault_over_abort got %b want 1001", {fault, abort, walk, dont_walk});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        goGreen();
    endtask

    task automatic test_reset_mid_walk();
        pressAndGrant();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if ({walk, dont_walk, flash, countdown, req_pending} !== 9'b0_1_0_00000_0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_walk got %b want 010000000",
                     {walk, dont_walk, flash, countdown, req_pending});
        end
        goGreen();
    endtask

    initial begin
        test_reset();
        test_walk_flash();
        test_no_press();
        test_press_at_red_rise();
        test_press_walk_flash();
        test_abort();
        test_fault();
        test_reset_mid_walk();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
